// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding, divisor width, data-length decode.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    // Baud counter width: the 16-bit divisor latch scaled by 16.
    localparam int DIV_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_tx_state_e;

    // cfg_bits 00/01/10/11 select 5/6/7/8 data bits; returns the index of the last data bit.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        return 3'd4 + {1'b0, bits};
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write channel from the register file (THR writes) into the transmitter FIFO.
// Latency: a write is taken at the clock edge where tx_valid and tx_ready are both high.
// Backpressure: tx_ready low while the FIFO is full; tx_ready never depends on tx_valid.
//   tx_data  : byte to transmit (bits above the configured length are ignored)
//   tx_valid : write request
//   tx_ready : FIFO has room
interface uart_tx_buffered_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data and occupancy count.
// Latency: pushed data is visible at o_pop_dat one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; rst_i flushes contents.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   i_push, i_push_dat   : write strobe and data
//   i_pop, o_pop_dat     : read strobe and head-of-queue data
//   o_full, o_empty      : status
//   o_level              : number of stored entries
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_push,
    input  logic [7:0]               i_push_dat,
    input  logic                     i_pop,
    output logic [7:0]               o_pop_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_level == (AW + 1)'(DEPTH));
    assign o_empty   = (o_level == '0);
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO of bytes serialised LSB first with start, 5-8 data, opt. even parity, 1-2 stop.
// Latency: tx_o falls one cycle after a byte is popped; every bit lasts {cfg_div_i,4'h0}+1 cycles.
// Backpressure: wr.tx_ready low while the FIFO is full; cfg_en_i low aborts the frame but keeps the FIFO.
//   clk_i, rst_i   : clock, synchronous active-high reset (flushes FIFO, aborts frame)
//   tx_o           : registered serial line, idle high
//   cfg_*          : divisor, enable, parity enable, data length, stop bit count (sampled live)
//   wr             : byte write channel (tx_data / tx_valid / tx_ready)
//   fifo_level_o   : FIFO occupancy
//   busy_o         : frame in progress or FIFO not empty
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          tx_o,
    input  logic [15:0]                   cfg_div_i,
    input  logic                          cfg_en_i,
    input  logic                          cfg_parity_en_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic                          cfg_stop_bits_i,
    uart_tx_buffered_if.slave             wr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o
);
    uart_tx_state_e   r_state;
    uart_tx_state_e   w_state_nxt;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [DIV_W-1:0] w_baud_term;
    logic             w_bit_done;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_par;
    logic             w_par_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_cnt_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_head;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_push     (wr.tx_valid),
        .i_push_dat (wr.tx_data),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (fifo_level_o)
    );

    assign wr.tx_ready = !w_full;
    assign busy_o      = (r_state != IDLE) || !w_empty;
    assign tx_o        = r_tx;

    // Bit period is terminal count + 1 cycles; the counter only runs inside a frame,
    // so every state starts its bit from zero.
    assign w_baud_term = {cfg_div_i, 4'h0};
    assign w_bit_done  = (r_state != IDLE) && (r_baud_cnt == w_baud_term);

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_bit_cnt_nxt = r_bit_cnt;
        w_pop         = 1'b0;
        if (!cfg_en_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_shift_nxt   = w_head;
                        w_par_nxt     = 1'b0;
                        w_bit_cnt_nxt = 3'd0;
                        w_state_nxt   = START;
                    end
                end
                START:  if (w_bit_done) w_state_nxt = DATA;
                DATA: begin
                    if (w_bit_done) begin
                        w_par_nxt     = r_par ^ r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == last_bit_idx(cfg_bits_i))
                            w_state_nxt = cfg_parity_en_i ? PARITY : STOP1;
                    end
                end
                PARITY: if (w_bit_done) w_state_nxt = STOP1;
                STOP1:  if (w_bit_done) w_state_nxt = cfg_stop_bits_i ? STOP2 : IDLE;
                STOP2:  if (w_bit_done) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end

        // Line level is derived from the next state so tx_o moves in step with the FSM.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_par_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
            if ((r_state == IDLE) || !cfg_en_i || w_bit_done)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frames are compared cycle by cycle with a bit-list model.
// Latency: not applicable.
// Backpressure: exercised by filling the FIFO while the transmitter is disabled.
module tb_uart_tx_buffered;
    logic        clk = 1'b0;
    logic        rst;
    logic        tx;
    logic [15:0] div;
    logic        en;
    logic        par_en;
    logic [1:0]  bits;
    logic        stop2;
    logic [3:0]  level;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    bit exp_bits[$];
    bit rx_samples[$];

    uart_tx_buffered_if wr_if();

    uart_tx_buffered #(.FIFO_DEPTH(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .tx_o            (tx),
        .cfg_div_i       (div),
        .cfg_en_i        (en),
        .cfg_parity_en_i (par_en),
        .cfg_bits_i      (bits),
        .cfg_stop_bits_i (stop2),
        .wr              (wr_if),
        .fifo_level_o    (level),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Expected line levels for one frame, one entry per bit period.
    task automatic model_frame(input logic [7:0] d);
        int n;
        int ones;
        n = 5 + int'(bits);
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (par_en) exp_bits.push_back((ones % 2) == 1);
        exp_bits.push_back(1'b1);
        if (stop2) exp_bits.push_back(1'b1);
    endtask

    task automatic push(input logic [7:0] d, output bit acc);
        wr_if.tx_data  = d;
        wr_if.tx_valid = 1'b1;
        acc = wr_if.tx_ready;
        @(negedge clk);
        wr_if.tx_valid = 1'b0;
    endtask

    task automatic wait_low(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL %s: tx_o never fell (timeout), required a start bit", name);
    endtask

    // Checks every cycle of a frame, then decodes it mid-bit like a receiver would.
    // Returns on the first idle cycle after the last stop bit.
    task automatic check_frame(input string name, input logic [7:0] d);
        bit ok;
        int p, bad, n, ones, mask;
        logic [7:0] rx;
        model_frame(d);
        wait_low(name, ok);
        if (!ok) return;
        p = int'(div) * 16 + 1;
        n = 5 + int'(bits);
        bad = 0;
        rx_samples.delete();
        for (int k = 0; k < exp_bits.size() * p; k++) begin
            if (tx !== exp_bits[k / p]) bad++;
            if ((k % p) == (p / 2)) rx_samples.push_back(tx);
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s frame: %0d cycles differ, required 0 (byte %02h)", name, bad, d);
        end
        rx = '0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            rx[i] = rx_samples[1 + i];
            if (rx_samples[1 + i]) ones++;
        end
        mask = (1 << n) - 1;
        checks++;
        if (rx !== 8'(int'(d) & mask)) begin
            failures++;
            $display("FAIL %s rx_byte: got %02h, required %02h", name, rx, 8'(int'(d) & mask));
        end
        if (par_en) begin
            checks++;
            if (((ones + int'(rx_samples[n + 1])) % 2) != 0) begin
                failures++;
                $display("FAIL %s rx_parity: parity error, ones=%0d parity_bit=%0b", name, ones, rx_samples[n + 1]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL reset_tx: got %b, required 1", tx); end
        checks++; if (wr_if.tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, required 1", wr_if.tx_ready); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d, required 0", level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        bit acc;
        div = 16'd1; bits = 2'b11; par_en = 1'b0; stop2 = 1'b0; en = 1'b1;
        push(8'h55, acc);
        checks++; if (tx !== 1'b1 || level !== 4'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL 8n1_queued: tx=%b level=%0d busy=%b, required 1/1/1", tx, level, busy);
        end
        @(negedge clk);
        checks++; if (tx !== 1'b0 || level !== 4'd0) begin
            failures++; $display("FAIL 8n1_pop_latency: tx=%b level=%0d, required 0/0", tx, level);
        end
        check_frame("8n1_55", 8'h55);
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL 8n1_end: tx=%b busy=%b, required 1/0", tx, busy);
        end
    endtask

    task automatic test_parity();
        bit acc;
        bits = 2'b10; par_en = 1'b1; stop2 = 1'b1;
        push(8'h07, acc);
        check_frame("7e2_07", 8'h07);
        checks++; if (rx_samples[8] !== 1'b1) begin failures++; $display("FAIL 7e2_07_parity: got %b, required 1", rx_samples[8]); end
        push(8'h03, acc);
        check_frame("7e2_03", 8'h03);
        checks++; if (rx_samples[8] !== 1'b0) begin failures++; $display("FAIL 7e2_03_parity: got %b, required 0", rx_samples[8]); end
    endtask

    task automatic test_5bit();
        bit acc;
        bits = 2'b00; par_en = 1'b0; stop2 = 1'b0;
        push(8'hFF, acc);
        check_frame("5n1_ff", 8'hFF);
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [7:0] q[$];
        logic [7:0] d;
        int stuck;
        en = 1'b0; bits = 2'b11; par_en = 1'b0; stop2 = 1'b0; div = 16'd1;
        stuck = 0;
        for (int i = 0; i < 9; i++) begin
            d = 8'($urandom);
            push(d, acc);
            if (acc) q.push_back(d);
            if (tx !== 1'b1) stuck++;
        end
        checks++; if (q.size() != 8) begin failures++; $display("FAIL fill_accepted: got %0d, required 8", q.size()); end
        checks++; if (wr_if.tx_ready !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b, required 0", wr_if.tx_ready); end
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL fill_level: got %0d, required 8", level); end
        repeat (10) @(negedge clk);
        if (tx !== 1'b1) stuck++;
        checks++; if (stuck != 0) begin failures++; $display("FAIL fill_tx_idle: %0d low samples, required 0", stuck); end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_frame("b2b", q[i]);
            if (i < 7) begin
                checks++; if (tx !== 1'b1) begin failures++; $display("FAIL b2b_gap_idle: got %b, required 1", tx); end
                @(negedge clk);
                checks++; if (tx !== 1'b0) begin failures++; $display("FAIL b2b_gap_len: got %b, required 0", tx); end
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_abort();
        bit acc, ok;
        logic [7:0] a, b, c;
        int hi;
        en = 1'b0; bits = 2'b11; par_en = 1'b0; stop2 = 1'b0; div = 16'd1;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        push(a, acc); push(b, acc); push(c, acc);
        en = 1'b1;
        wait_low("abort_start", ok);
        repeat (76) @(negedge clk);
        checks++; if (tx !== a[3]) begin failures++; $display("FAIL abort_bit3: got %b, required %b", tx, a[3]); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b1 || level !== 4'd2 || busy !== 1'b1) begin
            failures++; $display("FAIL abort_now: tx=%b level=%0d busy=%b, required 1/2/1", tx, level, busy);
        end
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx === 1'b1) hi++;
        end
        checks++; if (hi != 20) begin failures++; $display("FAIL abort_hold: %0d high samples, required 20", hi); end
        en = 1'b1;
        check_frame("abort_next", b);
        check_frame("abort_last", c);
    endtask

    task automatic test_rst_mid();
        bit acc, ok;
        en = 1'b0; bits = 2'b11; par_en = 1'b0; stop2 = 1'b0; div = 16'd1;
        for (int i = 0; i < 4; i++) push(8'($urandom), acc);
        en = 1'b1;
        wait_low("rst_start", ok);
        checks++; if (level !== 4'd3) begin failures++; $display("FAIL rst_pre_level: got %0d, required 3", level); end
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1 || level !== 4'd0 || busy !== 1'b0 || wr_if.tx_ready !== 1'b1) begin
            failures++; $display("FAIL rst_mid: tx=%b level=%0d busy=%b ready=%b, required 1/0/0/1", tx, level, busy, wr_if.tx_ready);
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_flushed: tx=%b busy=%b, required 1/0", tx, busy); end
    endtask

    task automatic test_random_loopback();
        bit acc;
        logic [7:0] d;
        en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bits   = 2'(c & 3);
            par_en = ((c >> 2) & 1) == 1;
            stop2  = ((c >> 3) & 1) == 1;
            div    = 16'($urandom_range(0, 3));
            d      = 8'($urandom);
            push(d, acc);
            check_frame("loopback", d);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; par_en = 1'b0; bits = 2'b11; stop2 = 1'b0; div = 16'd1;
        wr_if.tx_data = 8'h00; wr_if.tx_valid = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_5bit();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        test_random_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
